// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: datapath widths, the NOP bubble
// word and the fetch FSM encoding.
package fetch_stage_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 16;

  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface fetch_stage_if #(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
);
  logic                   req;
  logic [PC_WIDTH-1:0]    addr;
  logic                   ready;
  logic [INSTR_WIDTH-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Hold wins over flush, flush wins over load;
// with none asserted the register keeps its contents.
module if_id_reg #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 16'hF000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic                   flush,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] instr_d,
  input  logic [PC_WIDTH-1:0]    pc_d,
  output logic [INSTR_WIDTH-1:0] instr_p1,
  output logic [PC_WIDTH-1:0]    pc_p1,
  output logic                   vld_p1
);

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
    end else if (hold) begin
      instr_p1 <= instr_p1;
      pc_p1    <= pc_p1;
      vld_p1   <= vld_p1;
    end else if (flush) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
    end else if (load) begin
      instr_p1 <= instr_d;
      pc_p1    <= pc_d;
      vld_p1   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the imem request FSM, and feeds
// the IF/ID register under hazard-unit stall/flush and jump/branch redirects.
module fetch_stage #(
  parameter int                     PC_WIDTH    = fetch_stage_pkg::PC_WIDTH,
  parameter int                     INSTR_WIDTH = fetch_stage_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_stall_i,
  input  logic                   if_id_stall_i,
  input  logic                   flush_if_id_i,
  input  logic                   jump_i,
  input  logic [PC_WIDTH-1:0]    jump_target_i,
  input  logic                   pc_src_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  input  logic                   halt_i,
  fetch_stage_if.master          imem,
  output logic [INSTR_WIDTH-1:0] ifid_instr_o,
  output logic [PC_WIDTH-1:0]    ifid_pc_o,
  output logic                   ifid_valid_o,
  output logic [3:0]             ifid_opcode_o,
  output logic [3:0]             ifid_rs_o,
  output logic [3:0]             ifid_rt_o,
  output logic                   halted_o
);
  import fetch_stage_pkg::*;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                in_halt, redirect, stall, fetch_ok;
  logic                ifid_hold, ifid_flush, ifid_load;

  assign in_halt     = (state_q == ST_HALT);
  assign redirect    = jump_i | pc_src_i;
  assign redirect_pc = jump_i ? jump_target_i : branch_target_i;
  assign stall       = pc_stall_i | if_id_stall_i;
  assign pc_inc      = pc_q + PC_WIDTH'(1);

  // A response is consumed only when nothing of higher priority claims the edge;
  // a flush still consumes it (pc advances) but keeps it out of IF/ID.
  assign fetch_ok = !in_halt && imem.ready && !halt_i && !redirect && !stall;

  assign ifid_hold  = in_halt || (!halt_i && !redirect && !flush_if_id_i && stall);
  assign ifid_flush = !in_halt && (halt_i || redirect || flush_if_id_i || !fetch_ok);
  assign ifid_load  = fetch_ok && !flush_if_id_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (in_halt || halt_i) begin
      state_d = ST_HALT;
    end else if (redirect) begin
      state_d = ST_FETCH;
      pc_d    = redirect_pc;
    end else begin
      state_d = imem.ready ? ST_FETCH : ST_WAIT;
      if (fetch_ok) pc_d = pc_inc;
    end
  end

  // PC / FSM register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem.req  = !in_halt;
  assign imem.addr = pc_q;
  assign halted_o  = in_halt;

  if_id_reg #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .NOP_INSTR   (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .hold     (ifid_hold),
    .flush    (ifid_flush),
    .load     (ifid_load),
    .instr_d  (imem.rdata),
    .pc_d     (pc_inc),
    .instr_p1 (ifid_instr_o),
    .pc_p1    (ifid_pc_o),
    .vld_p1   (ifid_valid_o)
  );

  assign ifid_opcode_o = ifid_instr_o[INSTR_WIDTH-1 -: 4];
  assign ifid_rs_o     = ifid_instr_o[INSTR_WIDTH-5 -: 4];
  assign ifid_rt_o     = ifid_instr_o[INSTR_WIDTH-9 -: 4];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID contents are queued as stimulus
// is issued and checked by a monitor whenever a new valid instruction appears.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        pc_stall_i, if_id_stall_i, flush_if_id_i;
  logic        jump_i, pc_src_i, halt_i;
  logic [15:0] jump_target_i, branch_target_i;
  logic [15:0] ifid_instr_o, ifid_pc_o;
  logic        ifid_valid_o, halted_o;
  logic [3:0]  ifid_opcode_o, ifid_rs_o, ifid_rt_o;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ifid_t;

  ifid_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  fetch_stage_if #(.PC_WIDTH(16), .INSTR_WIDTH(16)) imem_if ();

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc_stall_i      (pc_stall_i),
    .if_id_stall_i   (if_id_stall_i),
    .flush_if_id_i   (flush_if_id_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .pc_src_i        (pc_src_i),
    .branch_target_i (branch_target_i),
    .halt_i          (halt_i),
    .imem            (imem_if.master),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_pc_o       (ifid_pc_o),
    .ifid_valid_o    (ifid_valid_o),
    .ifid_opcode_o   (ifid_opcode_o),
    .ifid_rs_o       (ifid_rs_o),
    .ifid_rt_o       (ifid_rt_o),
    .halted_o        (halted_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    pc_stall_i      = 1'b0;
    if_id_stall_i   = 1'b0;
    flush_if_id_i   = 1'b0;
    jump_i          = 1'b0;
    pc_src_i        = 1'b0;
    halt_i          = 1'b0;
    jump_target_i   = 16'h0000;
    branch_target_i = 16'h0000;
  endtask

  task automatic mem(input logic rdy, input logic [15:0] rd);
    imem_if.ready = rdy;
    imem_if.rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ifid(input logic [15:0] instr, input logic [15:0] pc);
    ifid_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation each time IF/ID presents a new valid instruction
  initial begin
    logic        last_v;
    logic [15:0] last_pc, last_in;
    ifid_t       e;
    last_v  = 1'b0;
    last_pc = 16'h0;
    last_in = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_v = 1'b0;
      end else begin
        if (ifid_valid_o && (!last_v || ifid_pc_o != last_pc || ifid_instr_o != last_in)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ifid_unexpected: got instr %h pc %h, required no valid instruction",
                     ifid_instr_o, ifid_pc_o);
          end else begin
            e = exp_q.pop_front();
            if (ifid_instr_o !== e.instr || ifid_pc_o !== e.pc) begin
              errors++;
              $display("FAIL ifid_data: got instr %h pc %h, required instr %h pc %h",
                       ifid_instr_o, ifid_pc_o, e.instr, e.pc);
            end
          end
        end
        last_v  = ifid_valid_o;
        last_pc = ifid_pc_o;
        last_in = ifid_instr_o;
      end
    end
  end

  initial begin
    clr();
    mem(1'b0, 16'h0000);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_addr", imem_if.addr, 16'h0000);
    chk("rst_req", imem_if.req, 1'b1);
    chk("rst_instr", ifid_instr_o, 16'hF000);
    chk("rst_pc", ifid_pc_o, 16'h0000);
    chk("rst_valid", ifid_valid_o, 1'b0);
    chk("rst_halted", halted_o, 1'b0);

    // Zero-wait streaming from pc 0
    mem(1'b1, 16'h2120); expect_ifid(16'h2120, 16'h0001); step();
    chk("stream_addr1", imem_if.addr, 16'h0001);
    chk("stream_op1", ifid_opcode_o, 4'h2);
    chk("stream_rs1", ifid_rs_o, 4'h1);
    chk("stream_rt1", ifid_rt_o, 4'h2);
    mem(1'b1, 16'h4340); expect_ifid(16'h4340, 16'h0002); step();
    chk("stream_addr2", imem_if.addr, 16'h0002);
    chk("stream_op2", ifid_opcode_o, 4'h4);
    mem(1'b1, 16'h6560); expect_ifid(16'h6560, 16'h0003); step();
    chk("stream_addr3", imem_if.addr, 16'h0003);

    // Memory wait at pc 3: two bubbles, address held
    for (int i = 0; i < 2; i++) begin
      mem(1'b0, 16'hDEAD); step();
      chk("wait_addr", imem_if.addr, 16'h0003);
      chk("wait_bubble", ifid_valid_o, 1'b0);
      chk("wait_req", imem_if.req, 1'b1);
    end
    mem(1'b1, 16'h8780); expect_ifid(16'h8780, 16'h0004); step();
    chk("wait_resume_pc", ifid_pc_o, 16'h0004);
    mem(1'b1, 16'hA9A0); expect_ifid(16'hA9A0, 16'h0005); step();
    chk("pre_stall_addr", imem_if.addr, 16'h0005);

    // Stall at pc 5 for three cycles; ready responses are dropped
    for (int i = 0; i < 3; i++) begin
      pc_stall_i = 1'b1; if_id_stall_i = 1'b1;
      mem(1'b1, 16'h1111); step();
      chk("stall_addr", imem_if.addr, 16'h0005);
      chk("stall_instr", ifid_instr_o, 16'hA9A0);
      chk("stall_pc", ifid_pc_o, 16'h0005);
      chk("stall_valid", ifid_valid_o, 1'b1);
    end
    clr();
    mem(1'b1, 16'hB0B0); expect_ifid(16'hB0B0, 16'h0006); step();
    chk("unstall_addr6", imem_if.addr, 16'h0006);
    mem(1'b1, 16'hC0C0); expect_ifid(16'hC0C0, 16'h0007); step();
    chk("unstall_addr7", imem_if.addr, 16'h0007);

    // Jump while waiting; the late response for pc 7 is discarded
    mem(1'b0, 16'h0000); step();
    jump_i = 1'b1; jump_target_i = 16'h0040;
    mem(1'b1, 16'hDEAD); step();
    clr();
    chk("jump_addr", imem_if.addr, 16'h0040);
    chk("jump_instr", ifid_instr_o, 16'hF000);
    chk("jump_valid", ifid_valid_o, 1'b0);
    mem(1'b1, 16'h1234); expect_ifid(16'h1234, 16'h0041); step();
    chk("jump_next", imem_if.addr, 16'h0041);

    // Jump beats branch in the same cycle
    jump_i = 1'b1; jump_target_i = 16'h0020;
    pc_src_i = 1'b1; branch_target_i = 16'h0010;
    mem(1'b1, 16'hDEAD); step();
    clr();
    chk("prio_addr", imem_if.addr, 16'h0020);
    chk("prio_valid", ifid_valid_o, 1'b0);
    pc_src_i = 1'b1; branch_target_i = 16'h0010;
    mem(1'b0, 16'h0000); step();
    clr();
    chk("branch_addr", imem_if.addr, 16'h0010);
    mem(1'b1, 16'h5678); expect_ifid(16'h5678, 16'h0011); step();

    // Flush: fetch consumed, pc advances, IF/ID gets a bubble
    flush_if_id_i = 1'b1;
    mem(1'b1, 16'h9999); step();
    clr();
    chk("flush_addr", imem_if.addr, 16'h0012);
    chk("flush_instr", ifid_instr_o, 16'hF000);
    chk("flush_valid", ifid_valid_o, 1'b0);

    // PC wrap at 0xFFFF
    jump_i = 1'b1; jump_target_i = 16'hFFFF;
    mem(1'b0, 16'h0000); step();
    clr();
    chk("wrap_pre", imem_if.addr, 16'hFFFF);
    mem(1'b1, 16'h7ABC); expect_ifid(16'h7ABC, 16'h0000); step();
    chk("wrap_addr", imem_if.addr, 16'h0000);
    chk("wrap_ifid_pc", ifid_pc_o, 16'h0000);
    chk("wrap_valid", ifid_valid_o, 1'b1);

    // Halt at pc 9, then try to disturb it for 20 cycles
    jump_i = 1'b1; jump_target_i = 16'h0009;
    mem(1'b0, 16'h0000); step();
    clr();
    halt_i = 1'b1;
    mem(1'b1, 16'hDEAD); step();
    clr();
    chk("halt_flag", halted_o, 1'b1);
    chk("halt_req", imem_if.req, 1'b0);
    chk("halt_bubble", ifid_valid_o, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [4:0] v;
      v = 5'(i);
      pc_stall_i      = v[0];
      if_id_stall_i   = v[1];
      jump_i          = v[2];
      pc_src_i        = v[3];
      flush_if_id_i   = v[4];
      jump_target_i   = 16'h0033;
      branch_target_i = 16'h0044;
      mem(1'b1, 16'hDEAD); step();
      chk("halt_hold_addr", imem_if.addr, 16'h0009);
      chk("halt_hold_req", imem_if.req, 1'b0);
      chk("halt_hold_flag", halted_o, 1'b1);
      chk("halt_hold_valid", ifid_valid_o, 1'b0);
    end
    clr();
    mem(1'b0, 16'h0000);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("rerst_addr", imem_if.addr, 16'h0000);
    chk("rerst_halted", halted_o, 1'b0);
    chk("rerst_req", imem_if.req, 1'b1);
    chk("rerst_valid", ifid_valid_o, 1'b0);

    step();
    step();
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
